exc_commit_ctrl: RTL and testbench
==================================

EXC_COMMIT_CTRL -- requirements
Module: exc_commit_ctrl

Interface
REQ-001 SHALL have parameter EX_VECTOR, default 32'hBFC00380, exception entry address (BEV=1).
REQ-002 SHALL have parameter SHADOW_CYC, default 2, interrupt-mask cycles after an MTC0 to Status or Cause.
REQ-003 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- ws_valid  in  1  WB-stage instruction valid.
- ws_pc  in  32  WB PC.
- ws_bd  in  1  WB instruction is in a delay slot.
- ws_ex  in  1  pipeline-detected exception.
- ws_excode  in  5  its ExcCode.
- ws_badvaddr  in  32  faulting address.
- ws_eret  in  1  ERET.
- ws_mtc0  in  1  MTC0.
- ws_c0_addr  in  8  {rd,sel} of MTC0.
- c0_status  in  32  CP0 Status.
- c0_cause  in  32  CP0 Cause.
- c0_epc  in  32  CP0 EPC.
- redirect_ready  in  1  fetch accepts redirect.
- wb_ex  out  1  exception commit pulse to CP0.
- eret_flush  out  1  ERET commit pulse to CP0.
- wb_excode  out  5  committed ExcCode.
- wb_pc  out  32  committed PC.
- wb_bd  out  1  committed BD.
- wb_badvaddr  out  32  committed BadVAddr.
- mtc0_we  out  1  gated CP0 write enable.
- pipe_flush  out  1  kill all younger stages.
- redirect_valid  out  1  redirect request.
- redirect_pc  out  32  redirect target.
- busy  out  1  not in IDLE.

Function
REQ-004 SHALL use states IDLE, DRAIN, REDIRECT; commit is evaluated only in IDLE with ws_valid=1.
REQ-005 SHALL compute int_req = Status[0] & ~Status[1] & |(Status[15:8] & Cause[15:8]) & (shadow==0).
REQ-006 SHALL use priority interrupt > ws_ex > ws_eret > ws_mtc0 for one commit.
REQ-007 Interrupt or ws_ex commit SHALL assert wb_ex=1 combinationally in the commit cycle.
- wb_excode = 5'h00 for interrupt, else ws_excode.
- wb_pc = ws_pc; wb_bd = ws_bd; wb_badvaddr = ws_badvaddr.
- Target EX_VECTOR is latched.
REQ-008 ERET commit (no higher event) SHALL assert eret_flush=1 for the commit cycle and latch c0_epc as target.
REQ-009 mtc0_we SHALL equal IDLE & ws_valid & ws_mtc0 & ~int_req & ~ws_ex.
REQ-010 An MTC0 commit to 8'h60 (Status) or 8'h68 (Cause) SHALL load shadow=SHADOW_CYC.
- shadow decrements by 1 per cycle to 0 and saturates.
REQ-011 wb_ex or eret_flush SHALL assert pipe_flush the same cycle and move FSM IDLE->DRAIN.
REQ-012 DRAIN SHALL keep pipe_flush=1 for exactly one cycle, then go to REDIRECT.
REQ-013 REDIRECT SHALL hold redirect_valid=1 and redirect_pc=latched target stable until redirect_ready=1, then return to IDLE next cycle.
REQ-014 redirect_ready=1 in the first REDIRECT cycle SHALL complete the handshake in one cycle.
REQ-015 In DRAIN and REDIRECT, ws_valid SHALL be ignored: no wb_ex, eret_flush or mtc0_we.
REQ-016 busy SHALL be 1 in DRAIN and REDIRECT.
REQ-017 wb_ex and eret_flush SHALL never both be 1; each SHALL be at most 1 cycle per commit.
REQ-018 redirect_ready while not in REDIRECT SHALL be ignored.

Reset
REQ-019 On reset: FSM=IDLE, shadow=0, latched target=0; redirect_valid, pipe_flush, busy, wb_ex, eret_flush, mtc0_we = 0.
REQ-020 Reset in DRAIN or REDIRECT SHALL abort the redirect; redirect_valid=0 the next cycle.

Verification
REQ-021 Syscall: ws_valid=1, ws_ex=1, excode=5'h08, pc=0xBFC00100, bd=0 -> wb_ex=1 one cycle, pipe_flush 2 cycles, then redirect_valid with redirect_pc=0xBFC00380 until ready.
REQ-022 Interrupt: Status=0x00000401, Cause IP[2]=1, ws_ex=1 same cycle -> wb_excode=0, interrupt wins.
REQ-023 MTC0 Status=0x0401 at addr 8'h60, pending IP[2] next cycle -> no wb_ex for 2 cycles, wb_ex on 3rd cycle.
REQ-024 ERET with c0_epc=0xBFC00200, redirect_ready low 3 cycles -> eret_flush 1 cycle, redirect_pc stable 0xBFC00200 for 4 cycles, IDLE after ready.
REQ-025 Reset asserted in REDIRECT -> redirect_valid=0, busy=0 next cycle, new ws_ex commits normally.
REQ-026 ws_valid=1 with ws_ex=1 during DRAIN -> no wb_ex, no mtc0_we.

Source files
------------

// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl
//   Commits exceptions, interrupts, ERET and MTC0 at the write-back stage.
//   Exceptions and ERET flush the younger pipeline stages. After that flush,
//   the block issues a fetch redirect and holds it until fetch accepts it.
//
// Parameters
//   EX_VECTOR   exception entry address (BEV=1)
//   SHADOW_CYC  interrupt-mask cycles after an MTC0 to Status or Cause
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   ws_*                  write-back stage instruction and its commit attributes
//   c0_status/cause/epc   current CP0 register values
//   redirect_ready        fetch accepts the redirect
//   wb_ex, eret_flush     one-cycle commit pulses to CP0
//   wb_excode/pc/bd/badvaddr  committed exception attributes
//   mtc0_we               gated CP0 write enable
//   pipe_flush            kill all younger stages
//   redirect_valid/pc     redirect request and its target
//   busy                  controller is not in IDLE
module exc_commit_ctrl #(
   parameter logic [31:0] EX_VECTOR  = 32'hBFC00380,
   parameter int unsigned SHADOW_CYC = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ws_valid,
   input  logic [31:0] ws_pc,
   input  logic        ws_bd,
   input  logic        ws_ex,
   input  logic [4:0]  ws_excode,
   input  logic [31:0] ws_badvaddr,
   input  logic        ws_eret,
   input  logic        ws_mtc0,
   input  logic [7:0]  ws_c0_addr,
   input  logic [31:0] c0_status,
   input  logic [31:0] c0_cause,
   input  logic [31:0] c0_epc,
   input  logic        redirect_ready,
   output logic        wb_ex,
   output logic        eret_flush,
   output logic [4:0]  wb_excode,
   output logic [31:0] wb_pc,
   output logic        wb_bd,
   output logic [31:0] wb_badvaddr,
   output logic        mtc0_we,
   output logic        pipe_flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy
);

   localparam int unsigned SW = (SHADOW_CYC < 1) ? 1 : $clog2(SHADOW_CYC + 1);

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      REDIRECT
   } state_t;

   state_t         state_q, state_d;
   logic [SW-1:0]  shadow_q, shadow_d;
   logic [31:0]    target_q, target_d;

   logic commit;
   logic int_req;
   logic take_int;
   logic take_ex;
   logic take_eret;
   logic shadow_hit;

   // Status/Cause bits that play no part in interrupt qualification
   logic unused_c0_bits;
   assign unused_c0_bits = ^{c0_status[31:16], c0_status[7:2],
                             c0_cause[31:16], c0_cause[7:0]};

   always_comb begin
      // Commit is also suppressed while reset is held, so no pulse leaks
      // to CP0 in the reset cycle itself.
      commit    = (state_q == IDLE) & ws_valid & ~reset;
      int_req   = c0_status[0] & ~c0_status[1]
                & (|(c0_status[15:8] & c0_cause[15:8]))
                & (shadow_q == '0);
      take_int  = commit & int_req;
      take_ex   = commit & ~int_req & ws_ex;
      take_eret = commit & ~int_req & ~ws_ex & ws_eret;

      wb_ex       = take_int | take_ex;
      eret_flush  = take_eret;
      wb_excode   = take_int ? 5'h00 : ws_excode;
      wb_pc       = ws_pc;
      wb_bd       = ws_bd;
      wb_badvaddr = ws_badvaddr;
      // An ERET alongside an MTC0 does not block the write; only
      // interrupt and exception do.
      mtc0_we     = commit & ws_mtc0 & ~int_req & ~ws_ex;

      pipe_flush     = wb_ex | eret_flush | (state_q == DRAIN);
      redirect_valid = (state_q == REDIRECT);
      redirect_pc    = target_q;
      busy           = (state_q != IDLE);
   end

   always_comb begin
      state_d    = state_q;
      target_d   = target_q;
      shadow_d   = shadow_q;
      shadow_hit = mtc0_we & ((ws_c0_addr == 8'h60) | (ws_c0_addr == 8'h68));

      if (shadow_hit) begin
         shadow_d = SW'(SHADOW_CYC);
      end else if (shadow_q != '0) begin
         shadow_d = shadow_q - 1'b1;
      end

      if (wb_ex) begin
         target_d = EX_VECTOR;
      end else if (eret_flush) begin
         target_d = c0_epc;
      end

      unique case (state_q)
         IDLE:     if (wb_ex | eret_flush) state_d = DRAIN;
         DRAIN:    state_d = REDIRECT;
         REDIRECT: if (redirect_ready) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         target_q <= target_d;
      end
   end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
module tb_exc_commit_ctrl;

   localparam logic [31:0] EXV = 32'hBFC00380;

   logic        clk = 1'b0;
   logic        reset;
   logic        ws_valid, ws_bd, ws_ex, ws_eret, ws_mtc0, redirect_ready;
   logic [31:0] ws_pc, ws_badvaddr, c0_status, c0_cause, c0_epc;
   logic [4:0]  ws_excode;
   logic [7:0]  ws_c0_addr;
   logic        wb_ex, eret_flush, wb_bd, mtc0_we, pipe_flush, redirect_valid, busy;
   logic [4:0]  wb_excode;
   logic [31:0] wb_pc, wb_badvaddr, redirect_pc;

   always #5 clk = ~clk;

   exc_commit_ctrl #(.EX_VECTOR(EXV), .SHADOW_CYC(2)) dut (
      .clk(clk), .reset(reset),
      .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_bd(ws_bd), .ws_ex(ws_ex),
      .ws_excode(ws_excode), .ws_badvaddr(ws_badvaddr), .ws_eret(ws_eret),
      .ws_mtc0(ws_mtc0), .ws_c0_addr(ws_c0_addr),
      .c0_status(c0_status), .c0_cause(c0_cause), .c0_epc(c0_epc),
      .redirect_ready(redirect_ready),
      .wb_ex(wb_ex), .eret_flush(eret_flush), .wb_excode(wb_excode),
      .wb_pc(wb_pc), .wb_bd(wb_bd), .wb_badvaddr(wb_badvaddr),
      .mtc0_we(mtc0_we), .pipe_flush(pipe_flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
   );

   typedef struct packed {
      logic [4:0]  excode;
      logic [31:0] pc;
      logic        bd;
      logic [31:0] bva;
      logic [31:0] tgt;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   total = 0;
   int   bad   = 0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in;
      ws_valid = 0; ws_bd = 0; ws_ex = 0; ws_eret = 0; ws_mtc0 = 0;
      ws_pc = '0; ws_badvaddr = '0; ws_excode = '0; ws_c0_addr = '0;
      redirect_ready = 0;
   endtask

   task automatic test_reset;
      reset = 1; clear_in(); c0_status = '0; c0_cause = '0; c0_epc = '0;
      tick(); tick();
      ws_valid = 1; ws_ex = 1; ws_eret = 1; ws_mtc0 = 1; ws_c0_addr = 8'h60;
      #1;
      total++;
      if ({wb_ex, eret_flush, mtc0_we, pipe_flush, busy, redirect_valid} !== 6'b0) begin
         bad++;
         $display("FAIL reset_outputs got=%b exp=000000",
                  {wb_ex, eret_flush, mtc0_we, pipe_flush, busy, redirect_valid});
      end
      tick(); reset = 0; clear_in();
   endtask

   task automatic test_syscall;
      tick();
      ws_valid = 1; ws_ex = 1; ws_excode = 5'h08; ws_pc = 32'hBFC00100; ws_bd = 0;
      ws_badvaddr = 32'h0000_1234;
      exp_q.push_back('{excode:5'h08, pc:32'hBFC00100, bd:1'b0, bva:32'h0000_1234, tgt:EXV});
      #1;
      total++;
      if ({wb_ex, pipe_flush, eret_flush} !== 3'b110) begin
         bad++; $display("FAIL syscall_pulse got=%b exp=110", {wb_ex, pipe_flush, eret_flush});
      end
      e = exp_q.pop_front();
      total++;
      if ({wb_excode, wb_pc, wb_bd, wb_badvaddr} !== {e.excode, e.pc, e.bd, e.bva}) begin
         bad++; $display("FAIL syscall_fields got=%h exp=%h",
                         {wb_excode, wb_pc, wb_bd, wb_badvaddr}, {e.excode, e.pc, e.bd, e.bva});
      end
      tick(); clear_in(); #1;
      total++;
      if ({wb_ex, pipe_flush, busy, redirect_valid} !== 4'b0110) begin
         bad++; $display("FAIL syscall_drain got=%b exp=0110", {wb_ex, pipe_flush, busy, redirect_valid});
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         redirect_ready = (i == 2);
         #1;
         total++;
         if ({pipe_flush, redirect_valid, redirect_pc} !== {1'b0, 1'b1, e.tgt}) begin
            bad++; $display("FAIL syscall_redirect%0d got=%b/%b/%h exp=0/1/%h",
                            i, pipe_flush, redirect_valid, redirect_pc, e.tgt);
         end
         tick();
      end
      redirect_ready = 0; #1;
      total++;
      if ({busy, redirect_valid} !== 2'b00) begin
         bad++; $display("FAIL syscall_idle got=%b exp=00", {busy, redirect_valid});
      end
   endtask

   task automatic test_interrupt;
      tick();
      c0_status = 32'h0000_0401; c0_cause = 32'h0000_0400;
      ws_valid = 1; ws_ex = 1; ws_eret = 1; ws_mtc0 = 1; ws_c0_addr = 8'h60;
      ws_excode = 5'h0A; ws_pc = 32'h8000_0040; ws_bd = 1; ws_badvaddr = 32'hDEAD_BEEF;
      exp_q.push_back('{excode:5'h00, pc:32'h8000_0040, bd:1'b1, bva:32'hDEAD_BEEF, tgt:EXV});
      #1;
      total++;
      if ({wb_ex, eret_flush, mtc0_we} !== 3'b100) begin
         bad++; $display("FAIL int_priority got=%b exp=100", {wb_ex, eret_flush, mtc0_we});
      end
      e = exp_q.pop_front();
      total++;
      if ({wb_excode, wb_pc, wb_bd, wb_badvaddr} !== {e.excode, e.pc, e.bd, e.bva}) begin
         bad++; $display("FAIL int_fields got=%h exp=%h",
                         {wb_excode, wb_pc, wb_bd, wb_badvaddr}, {e.excode, e.pc, e.bd, e.bva});
      end
      tick(); clear_in(); c0_status = '0;
      tick(); redirect_ready = 1; #1;
      total++;
      if ({redirect_valid, redirect_pc} !== {1'b1, e.tgt}) begin
         bad++; $display("FAIL int_redirect got=%b/%h exp=1/%h", redirect_valid, redirect_pc, e.tgt);
      end
      tick(); redirect_ready = 0; #1;
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL int_one_cycle_handshake got=%b exp=0", busy);
      end
   endtask

   task automatic test_mtc0_shadow;
      logic [7:0] addrs [3];
      int         lat_exp [3];
      int         lat;
      addrs = '{8'h60, 8'h68, 8'h70};
      lat_exp = '{3, 3, 1};
      for (int k = 0; k < 3; k++) begin
         tick(); clear_in();
         c0_status = '0; c0_cause = 32'h0000_0400;
         ws_valid = 1; ws_mtc0 = 1; ws_c0_addr = addrs[k]; ws_pc = 32'hBFC00300;
         #1;
         total++;
         if ({mtc0_we, wb_ex} !== 2'b10) begin
            bad++; $display("FAIL mtc0_we_%h got=%b exp=10", addrs[k], {mtc0_we, wb_ex});
         end
         tick();
         ws_mtc0 = 0; c0_status = 32'h0000_0401;
         exp_q.push_back('{excode:5'h00, pc:32'hBFC00300, bd:1'b0, bva:32'h0, tgt:EXV});
         lat = 0;
         for (int c = 1; c <= 6; c++) begin
            #1;
            if (wb_ex === 1'b1) begin
               lat = c;
               break;
            end
            tick();
         end
         total++;
         if (lat != lat_exp[k]) begin
            bad++; $display("FAIL shadow_latency_%h got=%0d exp=%0d", addrs[k], lat, lat_exp[k]);
         end
         e = exp_q.pop_front();
         total++;
         if ({wb_excode, wb_pc} !== {e.excode, e.pc}) begin
            bad++; $display("FAIL shadow_fields_%h got=%h exp=%h", addrs[k],
                            {wb_excode, wb_pc}, {e.excode, e.pc});
         end
         tick(); clear_in(); c0_status = '0;
         redirect_ready = 1;            // arrives in DRAIN, must be ignored there
         tick(); #1;
         total++;
         if ({redirect_valid, redirect_pc} !== {1'b1, e.tgt}) begin
            bad++; $display("FAIL shadow_redirect_%h got=%b/%h exp=1/%h", addrs[k],
                            redirect_valid, redirect_pc, e.tgt);
         end
         tick(); redirect_ready = 0;
      end
   endtask

   task automatic test_eret;
      int stable;
      tick(); clear_in(); c0_status = '0;
      redirect_ready = 1;
      tick(); #1;
      total++;
      if ({busy, redirect_valid} !== 2'b00) begin
         bad++; $display("FAIL idle_ready_ignored got=%b exp=00", {busy, redirect_valid});
      end
      redirect_ready = 0;
      tick();
      c0_epc = 32'hBFC00200; ws_valid = 1; ws_eret = 1; ws_pc = 32'hBFC00150;
      exp_q.push_back('{excode:5'h00, pc:32'hBFC00150, bd:1'b0, bva:32'h0, tgt:32'hBFC00200});
      #1;
      total++;
      if ({eret_flush, wb_ex, pipe_flush} !== 3'b101) begin
         bad++; $display("FAIL eret_pulse got=%b exp=101", {eret_flush, wb_ex, pipe_flush});
      end
      tick(); clear_in(); c0_epc = 32'h1111_1111; #1;
      total++;
      if ({eret_flush, pipe_flush, busy} !== 3'b011) begin
         bad++; $display("FAIL eret_drain got=%b exp=011", {eret_flush, pipe_flush, busy});
      end
      tick();
      e = exp_q.pop_front();
      stable = 0;
      for (int i = 0; i < 4; i++) begin
         redirect_ready = (i == 3);
         #1;
         if (redirect_valid === 1'b1 && redirect_pc === e.tgt) stable++;
         tick();
      end
      total++;
      if (stable != 4) begin
         bad++; $display("FAIL eret_redirect_stable got=%0d exp=4", stable);
      end
      redirect_ready = 0; #1;
      total++;
      if ({busy, redirect_valid} !== 2'b00) begin
         bad++; $display("FAIL eret_idle got=%b exp=00", {busy, redirect_valid});
      end
   endtask

   task automatic test_reset_in_redirect;
      tick(); ws_valid = 1; ws_ex = 1; ws_excode = 5'h04; ws_pc = 32'h8000_1000;
      tick(); clear_in();
      tick(); #1;
      total++;
      if (redirect_valid !== 1'b1) begin
         bad++; $display("FAIL rst_redirect_reached got=%b exp=1", redirect_valid);
      end
      reset = 1;
      tick(); reset = 0; #1;
      total++;
      if ({redirect_valid, busy, pipe_flush} !== 3'b000) begin
         bad++; $display("FAIL rst_abort got=%b exp=000", {redirect_valid, busy, pipe_flush});
      end
      ws_valid = 1; ws_ex = 1; ws_excode = 5'h0C; ws_pc = 32'h8000_2000;
      exp_q.push_back('{excode:5'h0C, pc:32'h8000_2000, bd:1'b0, bva:32'h0, tgt:EXV});
      #1;
      e = exp_q.pop_front();
      total++;
      if ({wb_ex, wb_excode, wb_pc} !== {1'b1, e.excode, e.pc}) begin
         bad++; $display("FAIL rst_new_commit got=%h exp=%h", {wb_ex, wb_excode, wb_pc},
                         {1'b1, e.excode, e.pc});
      end
      tick(); clear_in();
      tick(); redirect_ready = 1; #1;
      total++;
      if ({redirect_valid, redirect_pc} !== {1'b1, e.tgt}) begin
         bad++; $display("FAIL rst_new_redirect got=%b/%h exp=1/%h", redirect_valid, redirect_pc, e.tgt);
      end
      tick(); redirect_ready = 0;
   endtask

   task automatic test_drain_ignore;
      tick(); ws_valid = 1; ws_ex = 1; ws_excode = 5'h0D; ws_pc = 32'h8000_3000; #1;
      total++;
      if (wb_ex !== 1'b1) begin
         bad++; $display("FAIL ign_commit got=%b exp=1", wb_ex);
      end
      tick(); ws_mtc0 = 1; ws_eret = 1; ws_c0_addr = 8'h60; #1;
      total++;
      if ({wb_ex, eret_flush, mtc0_we, pipe_flush} !== 4'b0001) begin
         bad++; $display("FAIL ign_drain got=%b exp=0001", {wb_ex, eret_flush, mtc0_we, pipe_flush});
      end
      tick(); #1;
      total++;
      if ({wb_ex, eret_flush, mtc0_we, redirect_valid} !== 4'b0001) begin
         bad++; $display("FAIL ign_redirect got=%b exp=0001", {wb_ex, eret_flush, mtc0_we, redirect_valid});
      end
      clear_in(); redirect_ready = 1;
      tick(); redirect_ready = 0; #1;
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL ign_idle got=%b exp=0", busy);
      end
   endtask

   task automatic test_back_to_back;
      tick(); ws_valid = 1; ws_ex = 1; ws_excode = 5'h05; ws_pc = 32'h8000_4000;
      exp_q.push_back('{excode:5'h05, pc:32'h8000_4000, bd:1'b0, bva:32'h0, tgt:EXV});
      tick(); clear_in();
      tick(); redirect_ready = 1;
      e = exp_q.pop_front();
      #1;
      total++;
      if (redirect_pc !== e.tgt) begin
         bad++; $display("FAIL b2b_first_redirect got=%h exp=%h", redirect_pc, e.tgt);
      end
      tick(); redirect_ready = 0;
      c0_epc = 32'hBFC00480; ws_valid = 1; ws_eret = 1; ws_pc = 32'h8000_4004;
      exp_q.push_back('{excode:5'h00, pc:32'h8000_4004, bd:1'b0, bva:32'h0, tgt:32'hBFC00480});
      #1;
      total++;
      if ({eret_flush, wb_ex} !== 2'b10) begin
         bad++; $display("FAIL b2b_eret got=%b exp=10", {eret_flush, wb_ex});
      end
      tick(); clear_in();
      tick(); redirect_ready = 1;
      e = exp_q.pop_front();
      #1;
      total++;
      if ({redirect_valid, redirect_pc} !== {1'b1, e.tgt}) begin
         bad++; $display("FAIL b2b_second_redirect got=%b/%h exp=1/%h", redirect_valid, redirect_pc, e.tgt);
      end
      tick(); redirect_ready = 0;
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL scoreboard_drained got=%0d exp=0", exp_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_syscall();
      test_interrupt();
      test_mtc0_shadow();
      test_eret();
      test_reset_in_redirect();
      test_drain_ignore();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
